scan_receiver: RTL and testbench

SCAN_RECEIVER -- requirements
Module: scan_receiver

---
 rtl/scan_pkg.sv | 10 +
 rtl/sync_edge.sv | 35 +++
 rtl/scan_receiver.sv | 141 ++++++++++++++
 tb/tb_scan_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan link: receiver FSM encodings and default frame width.
package scan_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10
  } state_e;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a registered rising-edge pulse; lvl is aligned with rise.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              lvl_q, lvl_d;
  logic              rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    lvl_d  = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~lvl_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
endmodule

// File: rtl/scan_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, even parity, one-word
// output buffer with valid/ready handshake and a mid-frame inactivity timeout.
module scan_receiver
  import scan_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serialClkIn,
  input  logic             serialDataIn,
  output logic             readyForTransfer,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  input  logic             dataReady,
  output logic             parityErr,
  output logic             frameErr,
  output logic             overrun,
  output logic [1:0]       ps
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic ser_edge, ser_clk_lvl, ser_bit;

  sync_edge #(.STAGES(2)) u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (serialClkIn),
    .lvl  (ser_clk_lvl),
    .rise (ser_edge)
  );

  // Data path gets the same depth plus the alignment stage sync_edge adds.
  logic [2:0] dsync_q, dsync_d;
  assign ser_bit = dsync_q[2];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             rft_q, rft_d;
  logic             perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic             in_frame, tmo_hit, good;

  always_comb begin
    dsync_d   = {dsync_q[1:0], serialDataIn};
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = tmo_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    good      = 1'b0;
    in_frame  = (state_q == DATA) || (state_q == PARITY);
    tmo_hit   = in_frame && !ser_edge && (tmo_q == TMO_W'(TIMEOUT - 1));

    if (!in_frame || ser_edge)              tmo_d = '0;
    else if (tmo_q != TMO_W'(TIMEOUT - 1))  tmo_d = tmo_q + 1'b1;

    case (state_q)
      IDLE: if (ser_edge && ser_bit) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (ser_edge) begin
        shreg_d   = {shreg_q[WIDTH-2:0], ser_bit};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(WIDTH - 1)) state_d = PARITY;
      end
      PARITY: if (ser_edge) begin
        state_d = IDLE;
        if ((^shreg_q) == ser_bit) good = 1'b1;
        else                       perr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end

    // A full buffer can still take the new word if the consumer drains it this cycle.
    dv_d   = dv_q & ~dataReady;
    dout_d = dout_q;
    if (good) begin
      if (!dv_q || dataReady) begin
        dout_d = shreg_q;
        dv_d   = 1'b1;
      end else begin
        dv_d  = 1'b1;
        ovr_d = 1'b1;
      end
    end
    rft_d = ~dv_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dsync_q   <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tmo_q     <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      rft_q     <= 1'b1;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      dsync_q   <= dsync_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tmo_q     <= tmo_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      rft_q     <= rft_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign readyForTransfer = rft_q;
  assign dataOut          = dout_q;
  assign dataValid        = dv_q;
  assign parityErr        = perr_q;
  assign frameErr         = ferr_q;
  assign overrun          = ovr_q;
  assign ps               = state_q;

  logic unused_lvl;
  assign unused_lvl = ser_clk_lvl;
endmodule

// File: tb/tb_scan_receiver.sv
// Scoreboard bench for scan_receiver: expected words queued on send, checked on handshake.
module tb_scan_receiver;
  logic       clk = 1'b0, rst = 1'b0;
  logic       sclk = 1'b0, sdat = 1'b0, dready = 1'b0;
  logic       rft, dvalid, perr, ferr, ovr;
  logic [7:0] dout;
  logic [1:0] ps;

  scan_receiver #(.WIDTH(8), .TIMEOUT(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .serialClkIn      (sclk),
    .serialDataIn     (sdat),
    .readyForTransfer (rft),
    .dataOut          (dout),
    .dataValid        (dvalid),
    .dataReady        (dready),
    .parityErr        (perr),
    .frameErr         (ferr),
    .overrun          (ovr),
    .ps               (ps)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] sb[$];
  int  n_perr = 0, n_ferr = 0, n_ovr = 0, n_vld = 0, n_rft_hi = 0, n_rft_lo = 0;
  int  ferr_cyc = 0, vld_rise_cyc = 0;
  bit  vld_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (perr) n_perr <= n_perr + 1;
      if (ovr)  n_ovr  <= n_ovr + 1;
      if (ferr) begin
        n_ferr   <= n_ferr + 1;
        ferr_cyc <= cyc;
      end
      if (dvalid) n_vld <= n_vld + 1;
      if (dvalid && !vld_prev) vld_rise_cyc <= cyc;
      vld_prev <= dvalid;
      if (rft) n_rft_hi <= n_rft_hi + 1;
      else     n_rft_lo <= n_rft_lo + 1;
      if (dvalid && dready) begin
        if (sb.size() == 0) chk("sb_nonempty_on_pop", sb.size(), 1);
        else                chk("sb_word", dout, sb.pop_front());
      end
    end else begin
      vld_prev <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int last_rise = 0;
  task automatic send_bit(input logic b, input bit pulse_ready);
    sdat = b;
    tick(2);
    sclk = 1'b1;
    last_rise = cyc;
    if (pulse_ready) begin
      tick(3);
      dready = 1'b1;
      tick(1);
      dready = 1'b0;
      tick(1);
    end else begin
      tick(5);
    end
    sclk = 1'b0;
    tick(1);
  endtask

  task automatic send_frame(input logic [7:0] w, input bit bad_par, input bit pulse_last);
    send_bit(1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    send_bit((^w) ^ bad_par, pulse_last);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dvalid"}, dvalid, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_rft"}, rft, 1);
    chk({tag, "_ps"}, ps, 0);
    chk({tag, "_errs"}, {perr, ferr, ovr}, 0);
  endtask

  bit done = 1'b0;
  int v0, p0, o0, f0, h0, l0, lat;

  initial begin
    tick(3);
    chk_reset_outputs("rst");
    rst = 1'b1;
    tick(3);

    // Good frame, consumer always ready.
    dready = 1'b1;
    v0 = n_vld; p0 = n_perr; f0 = n_ferr;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0);
    tick(4);
    lat = vld_rise_cyc - last_rise;
    chk("a5_latency_le4", (lat >= 1 && lat <= 4), 1);
    chk("a5_valid_cycles", n_vld - v0, 1);
    chk("a5_perr", n_perr - p0, 0);
    chk("a5_ferr", n_ferr - f0, 0);
    chk("a5_ps", ps, 0);

    // Bad parity: word discarded.
    v0 = n_vld; p0 = n_perr; l0 = n_rft_lo;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(4);
    chk("badpar_perr_pulses", n_perr - p0, 1);
    chk("badpar_valid_cycles", n_vld - v0, 0);
    chk("badpar_rft_low_cycles", n_rft_lo - l0, 0);
    chk("badpar_ps", ps, 0);

    // Overrun: second word dropped while buffer held.
    dready = 1'b0;
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(2);
    chk("ovr_first_valid", dvalid, 1);
    o0 = n_ovr; h0 = n_rft_hi;
    send_frame(8'hC3, 1'b0, 1'b0);
    tick(4);
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_dout_held", dout, 8'h3C);
    chk("ovr_rft_high_cycles", n_rft_hi - h0, 0);
    chk("ovr_rft", rft, 0);
    dready = 1'b1;
    tick(3);
    chk("ovr_drained", sb.size(), 0);

    // Timeout mid-frame, then recovery.
    f0 = n_ferr;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    tick(70);
    chk("tmo_ferr_pulses", n_ferr - f0, 1);
    chk("tmo_ferr_cycle", ferr_cyc - last_rise, 68);
    chk("tmo_ps", ps, 0);
    v0 = n_vld;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0);
    tick(4);
    chk("tmo_next_valid_cycles", n_vld - v0, 1);
    chk("tmo_next_drained", sb.size(), 0);

    // Reset mid-frame with a word held in the buffer.
    dready = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0);
    tick(2);
    chk("rstmid_held_valid", dvalid, 1);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    sdat = 1'b1;
    tick(2);
    sclk = 1'b1;
    tick(1);
    f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rstmid");
    sb.delete();
    tick(3);
    sclk = 1'b0;
    sdat = 1'b0;
    rst = 1'b1;
    tick(3);
    dready = 1'b1;
    v0 = n_vld;
    sb.push_back(8'hFF);
    send_frame(8'hFF, 1'b0, 1'b0);
    tick(4);
    chk("rstmid_ff_valid_cycles", n_vld - v0, 1);
    chk("rstmid_no_err", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
    chk("rstmid_drained", sb.size(), 0);

    // Back-to-back with the consumer draining exactly as the second word lands.
    dready = 1'b0;
    o0 = n_ovr;
    sb.push_back(8'h01);
    sb.push_back(8'h02);
    send_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'h02, 1'b0, 1'b1);
    tick(2);
    chk("b2b_dout", dout, 8'h02);
    chk("b2b_valid", dvalid, 1);
    chk("b2b_no_ovr", n_ovr - o0, 0);
    dready = 1'b1;
    tick(3);
    chk("b2b_drained", sb.size(), 0);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    chk("watchdog_done", done, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
